// File: rtl/fp_vector_sequencer_if.sv
// Vector-ROM read port and DUT operand/result handshake used by fp_vector_sequencer.
// master = sequencer side, slave = ROM + unit-under-test side.
interface fp_vector_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int FLAGW = 5,
   parameter int ADDRW = 10
);
   logic [ADDRW-1:0]           vec_addr;
   logic                       vec_rd;
   logic [3*WIDTH+FLAGW-1:0]   vec_data;
   logic [WIDTH-1:0]           dut_op1;
   logic [WIDTH-1:0]           dut_op2;
   logic                       dut_start;
   logic                       dut_done;
   logic [WIDTH-1:0]           dut_result;
   logic [FLAGW-1:0]           dut_flags;

   modport master (
      output vec_addr, vec_rd, dut_op1, dut_op2, dut_start,
      input  vec_data, dut_done, dut_result, dut_flags
   );

   modport slave (
      input  vec_addr, vec_rd, dut_op1, dut_op2, dut_start,
      output vec_data, dut_done, dut_result, dut_flags
   );
endinterface

// File: rtl/fp_vector_sequencer.sv
// On-chip regression sequencer for multi-cycle FP units: ROM fetch, start strobe, done wait, compare.
// FP_CHK_NAN_EQUIV_EN: when defined, any NaN result matches a NaN expected value.
module fp_vector_sequencer #(
   parameter int WIDTH     = 32,
   parameter int FLAGW     = 5,
   parameter int ADDRW     = 10,
   parameter int START_CYC = 2,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic [ADDRW:0]       num_vec,
   fp_vector_sequencer_if.master bus,
   output logic                 busy,
   output logic                 finished,
   output logic [ADDRW:0]       vec_count,
   output logic [ADDRW:0]       err_count,
   output logic                 mismatch,
   output logic [ADDRW-1:0]     fail_idx,
   output logic                 timeout_seen
);
   localparam int VW  = 3*WIDTH + FLAGW;
   localparam int SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
   localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SCW-1:0]   START_LAST = SCW'(START_CYC - 1);
   localparam logic [TCW-1:0]   WAIT_LAST  = TCW'(TIMEOUT - 1);
   localparam logic [SCW-1:0]   SCNT_ONE   = SCW'(1);
   localparam logic [TCW-1:0]   WCNT_ONE   = TCW'(1);
   localparam logic [ADDRW:0]   IDX_ONE    = (ADDRW+1)'(1);
   localparam logic [ADDRW:0]   VEC_MAX    = IDX_ONE << ADDRW;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_CHECK, S_FINISH
   } state_t;

   state_t              state_q, state_d;
   logic [ADDRW:0]      idx_q, idx_d;
   logic [ADDRW:0]      nv_q, nv_d;
   logic [SCW-1:0]      scnt_q, scnt_d;
   logic [TCW-1:0]      wcnt_q, wcnt_d;
   logic [WIDTH-1:0]    op1_q, op1_d;
   logic [WIDTH-1:0]    op2_q, op2_d;
   logic [WIDTH-1:0]    yexp_q, yexp_d;
   logic [FLAGW-1:0]    fexp_q, fexp_d;
   logic [WIDTH-1:0]    res_q, res_d;
   logic [FLAGW-1:0]    flg_q, flg_d;
   logic                tout_q, tout_d;
   logic [ADDRW:0]      vcnt_q, vcnt_d;
   logic [ADDRW:0]      ecnt_q, ecnt_d;
   logic [ADDRW-1:0]    fidx_q, fidx_d;
   logic                tseen_q, tseen_d;

   logic [WIDTH-1:0]    rom_op1, rom_op2, rom_y;
   logic [FLAGW-1:0]    rom_flags;
   logic [ADDRW:0]      idx_nxt;
   logic                res_ok;
   logic                vec_fail;

   assign rom_op1   = bus.vec_data[VW-1 -: WIDTH];
   assign rom_op2   = bus.vec_data[VW-1-WIDTH -: WIDTH];
   assign rom_y     = bus.vec_data[FLAGW +: WIDTH];
   assign rom_flags = bus.vec_data[FLAGW-1:0];
   assign idx_nxt   = idx_q + IDX_ONE;

`ifdef FP_CHK_NAN_EQUIV_EN
   localparam int EXPW  = (WIDTH == 64) ? 11 : 8;
   localparam int FRACW = WIDTH - 1 - EXPW;

   function automatic logic is_nan(input logic [WIDTH-1:0] x);
      return (&x[WIDTH-2 -: EXPW]) && (|x[FRACW-1:0]);
   endfunction

   // Sign and payload are don't-care once both sides are NaN.
   assign res_ok = (res_q == yexp_q) || (is_nan(yexp_q) && is_nan(res_q));
`else
   assign res_ok = (res_q == yexp_q);
`endif

   // A timed-out vector fails regardless of whatever stale result is held.
   assign vec_fail = tout_q || !res_ok || (flg_q != fexp_q);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      nv_d    = nv_q;
      scnt_d  = scnt_q;
      wcnt_d  = wcnt_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      yexp_d  = yexp_q;
      fexp_d  = fexp_q;
      res_d   = res_q;
      flg_d   = flg_q;
      tout_d  = tout_q;
      vcnt_d  = vcnt_q;
      ecnt_d  = ecnt_q;
      fidx_d  = fidx_q;
      tseen_d = tseen_q;

      case (state_q)
         S_IDLE, S_FINISH: begin
            if (run) begin
               idx_d   = '0;
               nv_d    = (num_vec > VEC_MAX) ? VEC_MAX : num_vec;
               vcnt_d  = '0;
               ecnt_d  = '0;
               fidx_d  = '0;
               tseen_d = 1'b0;
               state_d = (num_vec == '0) ? S_FINISH : S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            op1_d   = rom_op1;
            op2_d   = rom_op2;
            yexp_d  = rom_y;
            fexp_d  = rom_flags;
            scnt_d  = '0;
            state_d = S_START;
         end
         S_START: begin
            if (scnt_q == START_LAST) begin
               wcnt_d  = '0;
               tout_d  = 1'b0;
               state_d = S_WAIT;
            end else begin
               scnt_d = scnt_q + SCNT_ONE;
            end
         end
         S_WAIT: begin
            // done wins on the last allowed cycle, so a reply at exactly TIMEOUT still counts.
            if (bus.dut_done) begin
               res_d   = bus.dut_result;
               flg_d   = bus.dut_flags;
               tout_d  = 1'b0;
               state_d = S_CHECK;
            end else if (wcnt_q == WAIT_LAST) begin
               tout_d  = 1'b1;
               state_d = S_CHECK;
            end else begin
               wcnt_d = wcnt_q + WCNT_ONE;
            end
         end
         S_CHECK: begin
            vcnt_d = vcnt_q + IDX_ONE;
            if (vec_fail) begin
               fidx_d = idx_q[ADDRW-1:0];
               if (ecnt_q != '1) begin
                  ecnt_d = ecnt_q + IDX_ONE;
               end
            end
            if (tout_q) begin
               tseen_d = 1'b1;
            end
            if (idx_nxt < nv_q) begin
               idx_d   = idx_nxt;
               state_d = S_FETCH;
            end else begin
               state_d = S_FINISH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         nv_q    <= '0;
         scnt_q  <= '0;
         wcnt_q  <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         yexp_q  <= '0;
         fexp_q  <= '0;
         res_q   <= '0;
         flg_q   <= '0;
         tout_q  <= 1'b0;
         vcnt_q  <= '0;
         ecnt_q  <= '0;
         fidx_q  <= '0;
         tseen_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         nv_q    <= nv_d;
         scnt_q  <= scnt_d;
         wcnt_q  <= wcnt_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         yexp_q  <= yexp_d;
         fexp_q  <= fexp_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
         tout_q  <= tout_d;
         vcnt_q  <= vcnt_d;
         ecnt_q  <= ecnt_d;
         fidx_q  <= fidx_d;
         tseen_q <= tseen_d;
      end
   end

   // Operands go out straight from ROM data during LOAD, then from the captured copy.
   assign bus.dut_op1   = (state_q == S_LOAD) ? rom_op1 : op1_q;
   assign bus.dut_op2   = (state_q == S_LOAD) ? rom_op2 : op2_q;
   assign bus.dut_start = (state_q == S_START);
   assign bus.vec_rd    = (state_q == S_FETCH);
   assign bus.vec_addr  = idx_q[ADDRW-1:0];

   assign busy         = (state_q != S_IDLE) && (state_q != S_FINISH);
   assign finished     = (state_q == S_FINISH);
   assign vec_count    = vcnt_q;
   assign err_count    = ecnt_q;
   assign mismatch     = (state_q == S_CHECK) && vec_fail;
   assign fail_idx     = fidx_q;
   assign timeout_seen = tseen_q;
endmodule

// File: tb/tb_fp_vector_sequencer.sv
// Directed bench: ROM + responder model, pass table with hand-computed results, reset corner sequence.
module tb_fp_vector_sequencer;
   localparam int WIDTH     = 32;
   localparam int FLAGW     = 5;
   localparam int ADDRW     = 4;
   localparam int START_CYC = 2;
   localparam int TIMEOUT   = 16;
   localparam int NROM      = 1 << ADDRW;
   localparam int VW        = 3*WIDTH + FLAGW;
   localparam int NVT       = 11;
   localparam int NPASS     = 7;
`ifdef FP_CHK_NAN_EQUIV_EN
   localparam bit NAN_EQ = 1'b1;
`else
   localparam bit NAN_EQ = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             run;
   logic [ADDRW:0]   num_vec;
   logic             busy, finished, mismatch, timeout_seen;
   logic [ADDRW:0]   vec_count, err_count;
   logic [ADDRW-1:0] fail_idx;

   always #5 clk = ~clk;

   fp_vector_sequencer_if #(.WIDTH(WIDTH), .FLAGW(FLAGW), .ADDRW(ADDRW)) bus ();

   fp_vector_sequencer #(
      .WIDTH(WIDTH), .FLAGW(FLAGW), .ADDRW(ADDRW), .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .run(run), .num_vec(num_vec), .bus(bus),
      .busy(busy), .finished(finished), .vec_count(vec_count), .err_count(err_count),
      .mismatch(mismatch), .fail_idx(fail_idx), .timeout_seen(timeout_seen)
   );

   // One ROM vector plus how the responder answers it (dly 0 = never answers).
   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] y_exp;
      logic [4:0]  f_exp;
      logic [31:0] res;
      logic [4:0]  flg;
      int          dly;
      bit          early;
      bit          fail;
   } vec_t;

   typedef struct {
      int base;
      bit uniform;
      int nv;
      int exp_vec;
      int exp_err;
      int exp_fidx;
      bit exp_tout;
      bit poke;
   } pass_t;

   vec_t  vt [NVT];
   pass_t pt [NPASS];

   logic [VW-1:0]    rom     [NROM];
   logic [31:0]      r_res   [NROM];
   logic [4:0]       r_flg   [NROM];
   int               r_dly   [NROM];
   bit               r_early [NROM];
   bit               r_fail  [NROM];

   int n_run  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (bus.vec_rd) bus.vec_data <= rom[bus.vec_addr];
   end

   // Responder: done arrives dly cycles after start falls; a wrong result shows during START.
   int m_cur = 0;
   int m_cnt = 0;
   bit m_armed = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         m_armed = 1'b0;
         bus.dut_done = 1'b0;
         bus.dut_result = r_res[m_cur];
      end else if (bus.dut_start) begin
         m_cur = int'(bus.vec_addr);
         m_armed = 1'b1;
         m_cnt = 0;
         bus.dut_done = r_early[m_cur];
         bus.dut_result = ~r_res[m_cur];
      end else begin
         bus.dut_result = r_res[m_cur];
         if (m_armed) begin
            m_cnt++;
            if (m_cnt == r_dly[m_cur]) begin
               bus.dut_done = 1'b1;
               m_armed = 1'b0;
            end else begin
               bus.dut_done = 1'b0;
            end
         end else begin
            bus.dut_done = 1'b0;
         end
      end
      bus.dut_flags = r_flg[m_cur];
   end

   task automatic load_pass(input int p);
      for (int i = 0; i < NROM; i++) begin
         int k;
         k = pt[p].uniform ? pt[p].base : pt[p].base + i;
         if (k >= NVT) k = 0;
         rom[i]     = {vt[k].op1, vt[k].op2, vt[k].y_exp, vt[k].f_exp};
         r_res[i]   = vt[k].res;
         r_flg[i]   = vt[k].flg;
         r_dly[i]   = vt[k].dly;
         r_early[i] = vt[k].early;
         r_fail[i]  = vt[k].fail;
      end
   endtask

   task automatic run_pass(input int p);
      int cyc, slen, mcnt, n, exp_lat;
      logic [NROM-1:0] mask, exp_mask;
      logic [VW-1:0] word;
      string tag;
      tag = $sformatf("pass%0d", p);
      load_pass(p);
      n = (pt[p].nv > NROM) ? NROM : pt[p].nv;
      exp_lat = 0;
      exp_mask = '0;
      for (int i = 0; i < n; i++) begin
         exp_lat += START_CYC + 3 + ((r_dly[i] == 0) ? TIMEOUT : r_dly[i]);
         exp_mask[i] = r_fail[i];
      end
      @(negedge clk);
      run = 1'b1;
      num_vec = (ADDRW+1)'(pt[p].nv);
      @(negedge clk);
      run = 1'b0;
      num_vec = '1;
      cyc = 0; slen = 0; mcnt = 0; mask = '0;
      while (!finished && cyc < 2000) begin
         if (bus.dut_start) begin
            if (slen == 0) begin
               word = rom[bus.vec_addr];
               chk({tag, "_op1"}, bus.dut_op1, word[VW-1 -: WIDTH]);
               chk({tag, "_op2"}, bus.dut_op2, word[VW-1-WIDTH -: WIDTH]);
            end
            slen++;
         end else if (slen != 0) begin
            chk({tag, "_start_len"}, slen, START_CYC);
            slen = 0;
         end
         if (mismatch) begin
            mcnt++;
            mask[bus.vec_addr] = 1'b1;
         end
         run = (pt[p].poke && cyc == 7);
         num_vec = run ? (ADDRW+1)'(1) : '1;
         @(negedge clk);
         cyc++;
      end
      run = 1'b0;
      chk({tag, "_finished"}, finished, 1);
      chk({tag, "_latency"}, cyc, exp_lat);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_vec_count"}, vec_count, pt[p].exp_vec);
      chk({tag, "_err_count"}, err_count, pt[p].exp_err);
      chk({tag, "_fail_idx"}, fail_idx, pt[p].exp_fidx);
      chk({tag, "_timeout_seen"}, timeout_seen, pt[p].exp_tout);
      chk({tag, "_mismatch_pulses"}, mcnt, pt[p].exp_err);
      chk({tag, "_fail_mask"}, mask, exp_mask);
   endtask

   initial begin
      int w;
      //          op1           op2           y_exp         f_exp  res           flg    dly early fail
      vt[0]  = '{32'h3F800000, 32'h40000000, 32'h3F000000, 5'h00, 32'h3F000000, 5'h00, 5,  0, 0};
      vt[1]  = '{32'h40400000, 32'h40000000, 32'h3FC00000, 5'h00, 32'h3FC00000, 5'h00, 5,  0, 0};
      vt[2]  = '{32'h40800000, 32'h40000000, 32'h40000000, 5'h00, 32'h40000000, 5'h00, 5,  0, 0};
      vt[3]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'h00, 32'h3F800000, 5'h00, 3,  0, 0};
      vt[4]  = '{32'h40000000, 32'h40000000, 32'h3F800000, 5'h00, 32'h3F800001, 5'h00, 2,  0, 1};
      vt[5]  = '{32'h40800000, 32'h40000000, 32'h40000000, 5'h00, 32'h40000000, 5'h00, 4,  1, 0};
      vt[6]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'h00, 32'h3F800000, 5'h01, 1,  0, 1};
      vt[7]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'h04, 32'h7F800000, 5'h04, 16, 0, 0};
      vt[8]  = '{32'h40000000, 32'h3F800000, 32'h40000000, 5'h00, 32'h40000000, 5'h00, 0,  0, 1};
      vt[9]  = '{32'h40400000, 32'h3F800000, 32'h40400000, 5'h00, 32'h40400000, 5'h00, 1,  0, 0};
      vt[10] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'h00, 32'hFFC00001, 5'h00, 2,  0, !NAN_EQ};

      //          base uni nv  vec err          fidx tout poke
      pt[0] = '{0,    0, 3,  3,  0,           0,   0,   1};
      pt[1] = '{3,    0, 3,  3,  1,           1,   0,   0};
      pt[2] = '{6,    0, 2,  2,  1,           0,   0,   0};
      pt[3] = '{8,    0, 2,  2,  1,           0,   1,   0};
      pt[4] = '{0,    0, 0,  0,  0,           0,   0,   0};
      pt[5] = '{10,   0, 1,  1,  NAN_EQ?0:1,  0,   0,   0};
      pt[6] = '{0,    1, 20, 16, 0,           0,   0,   0};

      reset = 1'b1;
      run = 1'b0;
      num_vec = '0;
      load_pass(0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_finished", finished, 0);
      chk("rst_vec_count", vec_count, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_mismatch", mismatch, 0);
      chk("rst_timeout_seen", timeout_seen, 0);
      chk("rst_vec_rd", bus.vec_rd, 0);
      chk("rst_dut_start", bus.dut_start, 0);
      chk("rst_dut_op1", bus.dut_op1, 0);

      for (int p = 0; p < NPASS; p++) run_pass(p);

      // Reset while vector 2 is waiting for done.
      load_pass(0);
      @(negedge clk);
      run = 1'b1;
      num_vec = 5'd3;
      @(negedge clk);
      run = 1'b0;
      w = 0;
      while (!(bus.vec_addr == 2 && bus.dut_start) && w < 200) begin
         @(negedge clk);
         w++;
      end
      while (bus.dut_start && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("mid_reached_wait", (w < 200) ? 1 : 0, 1);
      chk("mid_vec_count", vec_count, 2);
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_finished", finished, 0);
      chk("mid_rst_vec_count", vec_count, 0);
      chk("mid_rst_err_count", err_count, 0);
      chk("mid_rst_dut_op1", bus.dut_op1, 0);
      chk("mid_rst_dut_op2", bus.dut_op2, 0);
      chk("mid_rst_dut_start", bus.dut_start, 0);
      chk("mid_rst_vec_addr", bus.vec_addr, 0);
      repeat (3) @(negedge clk);
      chk("mid_rst_stays_idle", busy, 0);
      run = 1'b1;
      num_vec = '0;
      @(negedge clk);
      run = 1'b0;
      chk("zero_finished", finished, 1);
      chk("zero_busy", busy, 0);
      chk("zero_vec_count", vec_count, 0);
      chk("zero_err_count", err_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
